// File: rtl/soc.sv
// soc: UART boot monitor -- reads word 0, sends '>' plus that word, then loads UART bytes into memory.
// Define SOC_ECHO_EN to retransmit each byte received while loading.
module soc #(
    parameter int          CLKS_PER_BIT = 100,
    parameter logic [29:0] LOAD_BASE    = 30'h100
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic        I_uart_rx,
    output logic        O_uart_tx,
    output logic [29:0] O_mem_address,
    output logic [3:0]  O_mem_byte_we,
    output logic [31:0] O_mem_data_write,
    input  logic [31:0] I_mem_data_read,
    input  logic        I_mem_pause
);
    localparam int            CW   = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {BOOT_RD, TX_BANNER, TX_DUMP, LOAD} state_t;

    rx_state_t     rx_st_q;
    logic [1:0]    rx_sync_q;
    logic          rx_prev_q;
    logic          rx_valid_q;
    logic [CW-1:0] rx_cnt_q;
    logic [2:0]    rx_bit_q;
    logic [7:0]    rx_byte_q;
    logic          rx_s;

    logic          tx_q;
    logic          tx_busy_q;
    logic [CW-1:0] tx_cnt_q;
    logic [3:0]    tx_bit_q;
    logic [8:0]    tx_sh_q;
    logic          tx_ready;
    logic          tx_go;
    logic [7:0]    tx_byte;

    state_t        st_q;
    logic [31:0]   cap_q;
    logic [1:0]    idx_q;
    logic [1:0]    cnt_q;
    logic [23:0]   word_q;
    logic [31:0]   word_d;
    logic          pend_q;
    logic [31:0]   pend_data_q;
    logic [29:0]   ptr_q;
    logic [29:0]   addr_q;
    logic [3:0]    we_q;
    logic [31:0]   wdata_q;
    logic          rx_take;

    assign rx_s             = rx_sync_q[1];
    assign O_uart_tx        = tx_q;
    assign O_mem_address    = addr_q;
    assign O_mem_byte_we    = we_q;
    assign O_mem_data_write = wdata_q;
    assign word_d           = {word_q, rx_byte_q};
    assign rx_take          = rx_valid_q && st_q == LOAD;
    // Ready also on the final stop-bit cycle so the next frame follows with no gap.
    assign tx_ready         = !tx_busy_q || (tx_cnt_q == LAST && tx_bit_q == 4'd9);

`ifdef SOC_ECHO_EN
    assign tx_go   = tx_ready && (st_q == TX_BANNER || st_q == TX_DUMP || rx_take);
    assign tx_byte = st_q == TX_BANNER ? 8'h3E : st_q == TX_DUMP ? cap_q[{~idx_q, 3'b000} +: 8] : rx_byte_q;
`else
    assign tx_go   = tx_ready && (st_q == TX_BANNER || st_q == TX_DUMP);
    assign tx_byte = st_q == TX_BANNER ? 8'h3E : cap_q[{~idx_q, 3'b000} +: 8];
`endif

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            rx_sync_q  <= 2'b11;
            rx_prev_q  <= 1'b1;
            rx_st_q    <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_sync_q  <= {rx_sync_q[0], I_uart_rx};
            rx_prev_q  <= rx_s;
            rx_valid_q <= 1'b0;
            rx_cnt_q   <= rx_cnt_q + 1'b1;
            case (rx_st_q)
                RX_IDLE: begin
                    rx_cnt_q <= '0;
                    if (rx_prev_q && !rx_s) rx_st_q <= RX_START;
                end
                RX_START: if (rx_cnt_q == HALF) begin
                    rx_cnt_q <= '0;
                    rx_bit_q <= '0;
                    rx_st_q  <= rx_s ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (rx_cnt_q == LAST) begin
                    rx_cnt_q  <= '0;
                    rx_byte_q <= {rx_s, rx_byte_q[7:1]};
                    rx_bit_q  <= rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) rx_st_q <= RX_STOP;
                end
                RX_STOP: if (rx_cnt_q == LAST) begin
                    rx_valid_q <= rx_s;
                    rx_st_q    <= RX_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            tx_q      <= 1'b1;
            tx_busy_q <= 1'b0;
            tx_cnt_q  <= '0;
            tx_bit_q  <= '0;
            tx_sh_q   <= '1;
        end else if (tx_go) begin
            tx_q      <= 1'b0;
            tx_sh_q   <= {1'b1, tx_byte};
            tx_bit_q  <= '0;
            tx_cnt_q  <= '0;
            tx_busy_q <= 1'b1;
        end else if (tx_busy_q) begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
            if (tx_cnt_q == LAST) begin
                tx_cnt_q <= '0;
                tx_bit_q <= tx_bit_q + 1'b1;
                tx_q     <= tx_sh_q[0];
                tx_sh_q  <= {1'b1, tx_sh_q[8:1]};
                if (tx_bit_q == 4'd9) begin
                    tx_busy_q <= 1'b0;
                    tx_q      <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            st_q        <= BOOT_RD;
            cap_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            word_q      <= '0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            ptr_q       <= LOAD_BASE;
            addr_q      <= '0;
            we_q        <= '0;
            wdata_q     <= '0;
        end else begin
            case (st_q)
                BOOT_RD: if (!I_mem_pause) begin
                    cap_q <= I_mem_data_read;
                    st_q  <= TX_BANNER;
                end
                TX_BANNER: if (tx_ready) st_q <= TX_DUMP;
                TX_DUMP: if (tx_ready) begin
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == 2'd3) st_q <= LOAD;
                end
                LOAD: ;
            endcase
            if (we_q != 4'h0) begin
                if (!I_mem_pause) begin
                    we_q  <= 4'h0;
                    ptr_q <= ptr_q + 1'b1;
                end
            end else if (pend_q) begin
                addr_q  <= ptr_q;
                wdata_q <= pend_data_q;
                we_q    <= 4'hF;
                pend_q  <= 1'b0;
            end
            // A word finishing while a write is stalled waits in pend_data_q; this set overrides the clear above.
            if (rx_take) begin
                word_q <= word_d[23:0];
                cnt_q  <= cnt_q + 1'b1;
                if (cnt_q == 2'd3) begin
                    pend_q      <= 1'b1;
                    pend_data_q <= word_d;
                end
            end
        end
    end
endmodule

// File: tb/tb_soc.sv
// tb_soc: directed bench for soc with UART/memory scoreboards; define SOC_ECHO_EN to check echo.
module tb_soc;
    localparam int CPB = 100;
    localparam int GAP = 20;

    logic        clk;
    logic        rst_n;
    logic        rx;
    logic        tx;
    logic [29:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        pause;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    bit sent;

    logic [7:0]  exp_tx[$];
    logic [8:0]  tx_obs[$];
    int          tx_t[$];
    logic [74:0] exp_wr[$];
    logic [74:0] wr_obs[$];

    logic [7:0]  mb;
    int          mt;
    logic [65:0] wr_last;
    int          wr_len = 0;
    logic        wr_bad = 1'b0;

    soc #(.CLKS_PER_BIT(CPB), .LOAD_BASE(30'h100)) dut (
        .I_clk(clk),
        .I_rst_n(rst_n),
        .I_uart_rx(rx),
        .O_uart_tx(tx),
        .O_mem_address(addr),
        .O_mem_byte_we(we),
        .O_mem_data_write(wdata),
        .I_mem_data_read(rdata),
        .I_mem_pause(pause)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // UART decoder: samples each bit at its middle, records byte, stop bit and start cycle.
    initial forever begin
        @(negedge clk);
        if (tx === 1'b0) begin
            mt = cyc;
            repeat (CPB / 2) @(negedge clk);
            if (tx === 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    mb[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                tx_obs.push_back({tx, mb});
                tx_t.push_back(mt);
            end
        end
    end

    // Write monitor: records address, data, enables, cycles held and whether anything moved while held.
    initial forever begin
        @(negedge clk);
        if (we !== 4'h0) begin
            if (wr_len != 0 && {addr, wdata, we} !== wr_last) wr_bad = 1'b1;
            wr_last = {addr, wdata, we};
            wr_len++;
        end else if (wr_len != 0) begin
            wr_obs.push_back({wr_last, wr_len[7:0], wr_bad});
            wr_len = 0;
            wr_bad = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [74:0] wrec(input logic [29:0] a, input logic [31:0] d, input logic [7:0] n);
        return {a, d, 4'hF, n, 1'b0};
    endfunction

    task automatic uart_send(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic load_byte(input logic [7:0] b);
`ifdef SOC_ECHO_EN
        exp_tx.push_back(b);
`endif
        uart_send(b, 1'b1);
    endtask

    task automatic drain_tx(input bit spacing, output int first_t);
        int k;
        int prev;
        int t;
        logic [7:0] e;
        logic [8:0] o;
        first_t = -1;
        prev = 0;
        for (int i = 0; exp_tx.size() > 0; i++) begin
            k = 0;
            while (tx_obs.size() == 0 && k < 15 * CPB) begin
                @(negedge clk);
                k++;
            end
            chk("tx_timeout", tx_obs.size() > 0, 1'b1);
            if (tx_obs.size() == 0) begin
                exp_tx.delete();
                break;
            end
            e = exp_tx.pop_front();
            o = tx_obs.pop_front();
            t = tx_t.pop_front();
            chk("tx_frame", o, {1'b1, e});
            if (i == 0) first_t = t;
            else if (spacing) chk("tx_gap", t - prev, 10 * CPB);
            prev = t;
        end
    endtask

    task automatic drain_wr();
        int k;
        while (exp_wr.size() > 0) begin
            k = 0;
            while (wr_obs.size() == 0 && k < 15 * CPB) begin
                @(negedge clk);
                k++;
            end
            chk("wr_timeout", wr_obs.size() > 0, 1'b1);
            if (wr_obs.size() == 0) begin
                exp_wr.delete();
                break;
            end
            chk("wr_rec", wr_obs.pop_front(), exp_wr.pop_front());
        end
    endtask

    initial begin
        int k;
        int ft;
        int rel;
        rst_n = 1'b0;
        rx    = 1'b1;
        pause = 1'b0;
        rdata = 32'hDEADBEEF;
        sent  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rst_outputs", {tx, we, addr, wdata}, {1'b1, 4'h0, 30'h0, 32'h0});
        end
        exp_tx.push_back(8'h3E);
        exp_tx.push_back(8'hDE);
        exp_tx.push_back(8'hAD);
        exp_tx.push_back(8'hBE);
        exp_tx.push_back(8'hEF);
        rst_n = 1'b1;
        @(negedge clk);
        rdata = 32'h0;
        chk("boot_read", {we, addr}, {4'h0, 30'h0});
        repeat (100) @(negedge clk);
        uart_send(8'hAA, 1'b1);
        drain_tx(1'b1, ft);
        chk("boot_addr_hold", {we, addr}, {4'h0, 30'h0});

        load_byte(8'h12);
        load_byte(8'h34);
        load_byte(8'h56);
        load_byte(8'h78);
        load_byte(8'h9A);
        load_byte(8'hBC);
        load_byte(8'hDE);
        load_byte(8'hF0);
        exp_wr.push_back(wrec(30'h100, 32'h12345678, 8'd1));
        exp_wr.push_back(wrec(30'h101, 32'h9ABCDEF0, 8'd1));
        drain_wr();
        chk("idle_after_wr", {we, addr}, {4'h0, 30'h101});

        uart_send(8'h55, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        load_byte(8'h11);
        load_byte(8'h22);
        load_byte(8'h33);
        load_byte(8'h44);
        exp_wr.push_back(wrec(30'h102, 32'h11223344, 8'd1));
        drain_wr();

        pause = 1'b1;
        load_byte(8'h55);
        load_byte(8'h66);
        load_byte(8'h77);
        fork
            begin
                load_byte(8'h88);
                sent = 1'b1;
            end
        join_none
        k = 0;
        while (we === 4'h0 && k < 20 * CPB) begin
            @(negedge clk);
            k++;
        end
        chk("stall_we", we, 4'hF);
        repeat (5) @(negedge clk);
        pause = 1'b0;
        k = 0;
        while (!sent && k < 20 * CPB) begin
            @(negedge clk);
            k++;
        end
        exp_wr.push_back(wrec(30'h103, 32'h55667788, 8'd6));
        load_byte(8'h99);
        load_byte(8'hAA);
        load_byte(8'hBB);
        load_byte(8'hCC);
        exp_wr.push_back(wrec(30'h104, 32'h99AABBCC, 8'd1));
        drain_wr();

        load_byte(8'h41);
        repeat (12 * CPB) @(negedge clk);
        drain_tx(1'b0, ft);
        chk("tx_extra", tx_obs.size(), 0);
        chk("wr_extra", wr_obs.size(), 0);

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_async", {tx, we, addr, wdata}, {1'b1, 4'h0, 30'h0, 32'h0});
        repeat (5) @(negedge clk);
        rdata = 32'hCAFEF00D;
        pause = 1'b1;
        exp_tx.push_back(8'h3E);
        exp_tx.push_back(8'hCA);
        exp_tx.push_back(8'hFE);
        exp_tx.push_back(8'hF0);
        exp_tx.push_back(8'h0D);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("pause_hold", {tx, we, addr}, {1'b1, 4'h0, 30'h0});
        end
        pause = 1'b0;
        rel = cyc;
        @(negedge clk);
        rdata = 32'h0;
        drain_tx(1'b1, ft);
        chk("banner_after_pause", ft > rel, 1'b1);
        load_byte(8'h01);
        load_byte(8'h02);
        load_byte(8'h03);
        load_byte(8'h04);
        exp_wr.push_back(wrec(30'h100, 32'h01020304, 8'd1));
        drain_wr();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
